// File: rtl/backend_cfg_ctrl.sv
// Serial configuration controller: decodes 12-bit framed read/write commands on i_sdin
// into the backend register bank and shifts register contents back out on o_sdout.
module backend_cfg_ctrl #(
  parameter int RST_THR_HI = 12,
  parameter int RST_THR_LO = 8,
  parameter int RST_WAIT   = 5
) (
  input  logic       i_sclk,
  input  logic       i_resetbAll,
  input  logic       i_sdin,
  output logic [2:0] o_gain,
  output logic [4:0] o_thr_hi,
  output logic [4:0] o_thr_lo,
  output logic [4:0] o_ro_wait,
  output logic [4:0] o_mod_wait,
  output logic       o_cfg_valid,
  output logic       o_wr_pulse,
  output logic       o_err,
  output logic       o_busy,
  output logic       o_sdout,
  output logic       o_sdout_en
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RW    = 3'd1,
    S_ADDR  = 3'd2,
    S_DATA  = 3'd3,
    S_PAR   = 3'd4,
    S_STOP  = 3'd5,
    S_RDOUT = 3'd6
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [2:0] r_cnt;
  logic [8:0] r_frame;
  logic       r_par;
  logic [2:0] r_gain;
  logic [4:0] r_thr_hi;
  logic [4:0] r_thr_lo;
  logic [4:0] r_ro_wait;
  logic [4:0] r_mod_wait;
  logic       r_cfg_valid;
  logic       r_wr_pulse;
  logic       r_err;
  logic       r_busy;
  logic       r_sdout;
  logic       r_sdout_en;
  logic [2:0] r_err_cnt;
  logic [3:0] r_rd_shift;

  logic       w_rw;
  logic [2:0] w_addr;
  logic [4:0] w_data;
  logic       w_reject;
  logic       w_at_stop;
  logic       w_wr_ok;
  logic       w_rd_ok;
  logic       w_rej_evt;
  logic [4:0] w_rd_value;

  function automatic logic even_parity_ok(input logic [9:0] bits);
    return ~(^bits);
  endfunction

  // r_frame collects {RW, ADDR, DATA} MSB first; the STOP bit is still on i_sdin at edge S.
  assign w_rw      = r_frame[8];
  assign w_addr    = r_frame[7:5];
  assign w_data    = r_frame[4:0];
  assign w_at_stop = (r_state == S_STOP);
  assign w_wr_ok   = w_at_stop & ~w_reject & w_rw;
  assign w_rd_ok   = w_at_stop & ~w_reject & ~w_rw;
  assign w_rej_evt = w_at_stop & w_reject;

  // Frame rejection decision, evaluated against the bank contents before the write.
  always_comb begin
    w_reject = 1'b0;
    if (!even_parity_ok({r_frame, r_par}) || i_sdin || (w_addr == 3'd7)) begin
      w_reject = 1'b1;
    end else if (w_rw) begin
      if (r_cfg_valid || (w_addr == 3'd6)) begin
        w_reject = 1'b1;
      end else if ((w_addr == 3'd1) && (w_data < r_thr_lo)) begin
        w_reject = 1'b1;
      end else if ((w_addr == 3'd2) && (w_data > r_thr_hi)) begin
        w_reject = 1'b1;
      end else begin
        w_reject = 1'b0;
      end
    end else begin
      w_reject = 1'b0;
    end
  end

  // Readback multiplexer.
  always_comb begin
    w_rd_value = 5'd0;
    case (w_addr)
      3'd0:    w_rd_value = {2'b00, r_gain};
      3'd1:    w_rd_value = r_thr_hi;
      3'd2:    w_rd_value = r_thr_lo;
      3'd3:    w_rd_value = r_ro_wait;
      3'd4:    w_rd_value = r_mod_wait;
      3'd5:    w_rd_value = {4'b0000, r_cfg_valid};
      3'd6:    w_rd_value = {2'b00, r_err_cnt};
      default: w_rd_value = 5'd0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_sdin) w_next_state = S_RW;
        else        w_next_state = S_IDLE;
      end
      S_RW:   w_next_state = S_ADDR;
      S_ADDR: begin
        if (r_cnt == 3'd2) w_next_state = S_DATA;
        else               w_next_state = S_ADDR;
      end
      S_DATA: begin
        if (r_cnt == 3'd4) w_next_state = S_PAR;
        else               w_next_state = S_DATA;
      end
      S_PAR:  w_next_state = S_STOP;
      S_STOP: begin
        if (w_rd_ok) w_next_state = S_RDOUT;
        else         w_next_state = S_IDLE;
      end
      S_RDOUT: begin
        if (r_cnt == 3'd4) w_next_state = S_IDLE;
        else               w_next_state = S_RDOUT;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register, bit counter and busy flag; the counter restarts on every state change.
  always_ff @(posedge i_sclk or negedge i_resetbAll) begin
    if (!i_resetbAll) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= (w_next_state != r_state) ? 3'd0 : (r_cnt + 3'd1);
      r_busy  <= (w_next_state != S_IDLE);
    end
  end

  // Incoming frame shift register and parity bit capture.
  always_ff @(posedge i_sclk or negedge i_resetbAll) begin
    if (!i_resetbAll) begin
      r_frame <= 9'd0;
      r_par   <= 1'b0;
    end else if ((r_state == S_RW) || (r_state == S_ADDR) || (r_state == S_DATA)) begin
      r_frame <= {r_frame[7:0], i_sdin};
    end else if (r_state == S_PAR) begin
      r_par <= i_sdin;
    end
  end

  // Register bank, sticky GO, event pulses and saturating error counter.
  always_ff @(posedge i_sclk or negedge i_resetbAll) begin
    if (!i_resetbAll) begin
      r_gain      <= 3'd0;
      r_thr_hi    <= 5'(RST_THR_HI);
      r_thr_lo    <= 5'(RST_THR_LO);
      r_ro_wait   <= 5'(RST_WAIT);
      r_mod_wait  <= 5'(RST_WAIT);
      r_cfg_valid <= 1'b0;
      r_wr_pulse  <= 1'b0;
      r_err       <= 1'b0;
      r_err_cnt   <= 3'd0;
    end else begin
      r_wr_pulse <= w_wr_ok;
      r_err      <= w_rej_evt;
      if (w_wr_ok) begin
        case (w_addr)
          3'd0:    r_gain     <= w_data[2:0];
          3'd1:    r_thr_hi   <= w_data;
          3'd2:    r_thr_lo   <= w_data;
          3'd3:    r_ro_wait  <= w_data;
          3'd4:    r_mod_wait <= w_data;
          3'd5:    if (w_data[0]) r_cfg_valid <= 1'b1;
          default: ;
        endcase
      end
      if (w_rej_evt && (r_err_cnt != 3'd7)) begin
        r_err_cnt <= r_err_cnt + 3'd1;
      end
    end
  end

  // Serial readout: the value is latched at edge S so later bank changes cannot corrupt it.
  always_ff @(posedge i_sclk or negedge i_resetbAll) begin
    if (!i_resetbAll) begin
      r_sdout    <= 1'b0;
      r_sdout_en <= 1'b0;
      r_rd_shift <= 4'd0;
    end else if (w_rd_ok) begin
      r_sdout    <= w_rd_value[4];
      r_rd_shift <= w_rd_value[3:0];
      r_sdout_en <= 1'b1;
    end else if (r_state == S_RDOUT) begin
      if (r_cnt == 3'd4) begin
        r_sdout    <= 1'b0;
        r_sdout_en <= 1'b0;
        r_rd_shift <= 4'd0;
      end else begin
        r_sdout    <= r_rd_shift[3];
        r_rd_shift <= {r_rd_shift[2:0], 1'b0};
      end
    end else begin
      r_sdout    <= 1'b0;
      r_sdout_en <= 1'b0;
    end
  end

  assign o_gain      = r_gain;
  assign o_thr_hi    = r_thr_hi;
  assign o_thr_lo    = r_thr_lo;
  assign o_ro_wait   = r_ro_wait;
  assign o_mod_wait  = r_mod_wait;
  assign o_cfg_valid = r_cfg_valid;
  assign o_wr_pulse  = r_wr_pulse;
  assign o_err       = r_err;
  assign o_busy      = r_busy;
  assign o_sdout     = r_sdout;
  assign o_sdout_en  = r_sdout_en;

endmodule

// File: tb/tb_backend_cfg_ctrl.sv
// Bench for backend_cfg_ctrl: directed frame table, hand-written reset sequences and
// randomized frames compared against a register-level reference model.
module tb_backend_cfg_ctrl;

  logic       i_sclk;
  logic       i_resetbAll;
  logic       i_sdin;
  logic [2:0] o_gain;
  logic [4:0] o_thr_hi;
  logic [4:0] o_thr_lo;
  logic [4:0] o_ro_wait;
  logic [4:0] o_mod_wait;
  logic       o_cfg_valid;
  logic       o_wr_pulse;
  logic       o_err;
  logic       o_busy;
  logic       o_sdout;
  logic       o_sdout_en;

  backend_cfg_ctrl #(.RST_THR_HI(12), .RST_THR_LO(8), .RST_WAIT(5)) dut (
    .i_sclk      (i_sclk),
    .i_resetbAll (i_resetbAll),
    .i_sdin      (i_sdin),
    .o_gain      (o_gain),
    .o_thr_hi    (o_thr_hi),
    .o_thr_lo    (o_thr_lo),
    .o_ro_wait   (o_ro_wait),
    .o_mod_wait  (o_mod_wait),
    .o_cfg_valid (o_cfg_valid),
    .o_wr_pulse  (o_wr_pulse),
    .o_err       (o_err),
    .o_busy      (o_busy),
    .o_sdout     (o_sdout),
    .o_sdout_en  (o_sdout_en)
  );

  initial i_sclk = 1'b0;
  always #5 i_sclk = ~i_sclk;

  int n_checks = 0;
  int n_errs   = 0;

  typedef struct {
    logic       rw;
    logic [2:0] addr;
    logic [4:0] data;
    logic       bad;
    logic       stop;
    int         exp_wr;
    int         exp_err;
    int         exp_rd;
  } vec_t;

  vec_t tbl [22];

  // reference model state
  int m_gain, m_hi, m_lo, m_ro, m_mod, m_valid, m_errc;

  function automatic vec_t mk(logic rw, logic [2:0] addr, logic [4:0] data, logic bad,
                              logic stop, int ew, int ee, int er);
    vec_t v;
    v.rw = rw; v.addr = addr; v.data = data; v.bad = bad; v.stop = stop;
    v.exp_wr = ew; v.exp_err = ee; v.exp_rd = er;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errs++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic do_reset();
    i_resetbAll = 1'b0;
    i_sdin      = 1'b0;
    repeat (3) @(negedge i_sclk);
    i_resetbAll = 1'b1;
    @(negedge i_sclk);
    m_gain = 0; m_hi = 12; m_lo = 8; m_ro = 5; m_mod = 5; m_valid = 0; m_errc = 0;
  endtask

  function automatic logic [11:0] build(logic rw, logic [2:0] addr, logic [4:0] data,
                                        logic bad, logic stop);
    logic par;
    par = (^{rw, addr, data}) ^ bad;
    return {1'b1, rw, addr, data, par, stop};
  endfunction

  // Called at a negedge; drives 12 bits and returns at the negedge after edge S.
  task automatic drive12(input logic [11:0] v);
    for (int i = 11; i >= 0; i--) begin
      i_sdin = v[i];
      @(negedge i_sclk);
      if (i == 11) check("busy_after_start", int'(o_busy), 1);
    end
    i_sdin = 1'b0;
  endtask

  // Drives one frame and observes six cycles after edge S; leaves i_sdin low at a negedge.
  task automatic frame(input logic rw, input logic [2:0] addr, input logic [4:0] data,
                       input logic bad, input logic stop,
                       output int n_wr, output int n_er, output int n_en,
                       output logic [4:0] rd, output logic busy_end);
    drive12(build(rw, addr, data, bad, stop));
    n_wr = 0; n_er = 0; n_en = 0; rd = 5'd0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge i_sclk);
      if (o_wr_pulse) n_wr++;
      if (o_err)      n_er++;
      if (o_sdout_en) n_en++;
      if (k < 5) rd = {rd[3:0], o_sdout};
    end
    busy_end = o_busy;
  endtask

  // Frame outcome from the register-map rules, updating the model bank.
  task automatic model_frame(input int rw, input int addr, input int data, input int bad,
                             input int stop, output int ew, output int ee, output int er);
    int rej;
    rej = (bad != 0) || (stop != 0) || (addr == 7) ||
          ((rw != 0) && ((addr == 6) || (m_valid != 0) ||
                         ((addr == 1) && (data < m_lo)) ||
                         ((addr == 2) && (data > m_hi))));
    ew = 0; ee = 0; er = -1;
    if (rej != 0) begin
      ee = 1;
      m_errc = (m_errc < 7) ? m_errc + 1 : 7;
    end else if (rw != 0) begin
      ew = 1;
      case (addr)
        0: m_gain = data % 8;
        1: m_hi   = data;
        2: m_lo   = data;
        3: m_ro   = data;
        4: m_mod  = data;
        5: if (data % 2 == 1) m_valid = 1;
        default: ;
      endcase
    end else begin
      case (addr)
        0: er = m_gain;
        1: er = m_hi;
        2: er = m_lo;
        3: er = m_ro;
        4: er = m_mod;
        5: er = m_valid;
        6: er = m_errc;
        default: er = 0;
      endcase
    end
  endtask

  initial begin
    int n_wr, n_er, n_en, ew, ee, er;
    logic [4:0] rd;
    logic busy_end;
    logic rw, bad, stop;
    logic [2:0] addr;
    logic [4:0] data;

    tbl[0]  = mk(1'b1, 3'd0, 5'd5,  1'b0, 1'b0, 1, 0, -1);
    tbl[1]  = mk(1'b0, 3'd1, 5'd0,  1'b0, 1'b0, 0, 0, 12);
    tbl[2]  = mk(1'b1, 3'd0, 5'd3,  1'b1, 1'b0, 0, 1, -1);
    tbl[3]  = mk(1'b0, 3'd0, 5'd0,  1'b0, 1'b0, 0, 0, 5);
    tbl[4]  = mk(1'b1, 3'd0, 5'd1,  1'b0, 1'b1, 0, 1, -1);
    tbl[5]  = mk(1'b0, 3'd6, 5'd0,  1'b0, 1'b0, 0, 0, 2);
    tbl[6]  = mk(1'b1, 3'd2, 5'd13, 1'b0, 1'b0, 0, 1, -1);
    tbl[7]  = mk(1'b1, 3'd1, 5'd7,  1'b0, 1'b0, 0, 1, -1);
    tbl[8]  = mk(1'b1, 3'd2, 5'd12, 1'b0, 1'b0, 1, 0, -1);
    tbl[9]  = mk(1'b0, 3'd2, 5'd0,  1'b0, 1'b0, 0, 0, 12);
    tbl[10] = mk(1'b0, 3'd7, 5'd0,  1'b0, 1'b0, 0, 1, -1);
    tbl[11] = mk(1'b1, 3'd6, 5'd3,  1'b0, 1'b0, 0, 1, -1);
    tbl[12] = mk(1'b1, 3'd3, 5'd9,  1'b0, 1'b0, 1, 0, -1);
    tbl[13] = mk(1'b1, 3'd4, 5'd17, 1'b0, 1'b0, 1, 0, -1);
    tbl[14] = mk(1'b1, 3'd5, 5'd0,  1'b0, 1'b0, 1, 0, -1);
    tbl[15] = mk(1'b0, 3'd5, 5'd0,  1'b0, 1'b0, 0, 0, 0);
    tbl[16] = mk(1'b1, 3'd5, 5'd1,  1'b0, 1'b0, 1, 0, -1);
    tbl[17] = mk(1'b0, 3'd5, 5'd0,  1'b0, 1'b0, 0, 0, 1);
    tbl[18] = mk(1'b1, 3'd0, 5'd2,  1'b0, 1'b0, 0, 1, -1);
    tbl[19] = mk(1'b0, 3'd0, 5'd0,  1'b0, 1'b0, 0, 0, 5);
    tbl[20] = mk(1'b1, 3'd0, 5'd4,  1'b1, 1'b0, 0, 1, -1);
    tbl[21] = mk(1'b0, 3'd6, 5'd0,  1'b0, 1'b0, 0, 0, 7);

    i_resetbAll = 1'b0;
    i_sdin      = 1'b0;
    do_reset();

    check("rst_gain",     int'(o_gain),      0);
    check("rst_thr_hi",   int'(o_thr_hi),    12);
    check("rst_thr_lo",   int'(o_thr_lo),    8);
    check("rst_ro_wait",  int'(o_ro_wait),   5);
    check("rst_mod_wait", int'(o_mod_wait),  5);
    check("rst_valid",    int'(o_cfg_valid), 0);
    check("rst_wr_pulse", int'(o_wr_pulse),  0);
    check("rst_err",      int'(o_err),       0);
    check("rst_busy",     int'(o_busy),      0);
    check("rst_sdout",    int'(o_sdout),     0);
    check("rst_sdout_en", int'(o_sdout_en),  0);

    // ten idle zeros must not start a frame
    repeat (10) @(negedge i_sclk);
    check("idle_zeros_busy", int'(o_busy), 0);

    // Directed table; reads are followed back-to-back by the next frame's start bit.
    for (int t = 0; t < 22; t++) begin
      frame(tbl[t].rw, tbl[t].addr, tbl[t].data, tbl[t].bad, tbl[t].stop,
            n_wr, n_er, n_en, rd, busy_end);
      check($sformatf("tbl%0d_wr_pulses", t), n_wr, tbl[t].exp_wr);
      check($sformatf("tbl%0d_err_pulses", t), n_er, tbl[t].exp_err);
      check($sformatf("tbl%0d_sdout_en_cycles", t), n_en, (tbl[t].exp_rd >= 0) ? 5 : 0);
      check($sformatf("tbl%0d_busy_end", t), int'(busy_end), 0);
      if (tbl[t].exp_rd >= 0) check($sformatf("tbl%0d_readback", t), int'(rd), tbl[t].exp_rd);
    end
    check("tbl_end_gain",     int'(o_gain),      5);
    check("tbl_end_thr_hi",   int'(o_thr_hi),    12);
    check("tbl_end_thr_lo",   int'(o_thr_lo),    12);
    check("tbl_end_ro_wait",  int'(o_ro_wait),   9);
    check("tbl_end_mod_wait", int'(o_mod_wait),  17);
    check("tbl_end_valid",    int'(o_cfg_valid), 1);

    // Reset asserted in the middle of a THR_HI readout.
    drive12(build(1'b0, 3'd1, 5'd0, 1'b0, 1'b0));
    check("midrd_sdout_en", int'(o_sdout_en), 1);
    @(negedge i_sclk);
    #2;
    i_resetbAll = 1'b0;
    #1;
    check("midrd_rst_sdout_en", int'(o_sdout_en),  0);
    check("midrd_rst_valid",    int'(o_cfg_valid), 0);
    check("midrd_rst_busy",     int'(o_busy),      0);
    check("midrd_rst_sdout",    int'(o_sdout),     0);
    @(negedge i_sclk);
    i_resetbAll = 1'b1;
    @(negedge i_sclk);

    // Reset in the middle of a frame, then a clean gain write must still work.
    for (int i = 11; i >= 6; i--) begin
      logic [11:0] v;
      v = build(1'b1, 3'd0, 5'd6, 1'b0, 1'b0);
      i_sdin = v[i];
      @(negedge i_sclk);
    end
    i_resetbAll = 1'b0;
    i_sdin      = 1'b0;
    #1;
    check("midfr_rst_busy", int'(o_busy), 0);
    @(negedge i_sclk);
    i_resetbAll = 1'b1;
    @(negedge i_sclk);
    frame(1'b1, 3'd0, 5'd6, 1'b0, 1'b0, n_wr, n_er, n_en, rd, busy_end);
    check("post_rst_wr_pulse", n_wr, 1);
    check("post_rst_gain", int'(o_gain), 6);

    // Randomized frames against the reference model.
    do_reset();
    for (int it = 0; it < 160; it++) begin
      rw   = 1'($urandom_range(0, 1));
      addr = 3'($urandom_range(0, 7));
      data = 5'($urandom_range(0, 31));
      bad  = ($urandom_range(0, 7) == 0);
      stop = ($urandom_range(0, 7) == 0);
      if (rw && (addr == 3'd5) && (it < 130)) data[0] = 1'b0;
      model_frame(int'(rw), int'(addr), int'(data), int'(bad), int'(stop), ew, ee, er);
      frame(rw, addr, data, bad, stop, n_wr, n_er, n_en, rd, busy_end);
      check($sformatf("rnd%0d_wr_pulses", it), n_wr, ew);
      check($sformatf("rnd%0d_err_pulses", it), n_er, ee);
      check($sformatf("rnd%0d_sdout_en_cycles", it), n_en, (er >= 0) ? 5 : 0);
      if (er >= 0) check($sformatf("rnd%0d_readback", it), int'(rd), er);
      check($sformatf("rnd%0d_gain", it),     int'(o_gain),      m_gain);
      check($sformatf("rnd%0d_thr_hi", it),   int'(o_thr_hi),    m_hi);
      check($sformatf("rnd%0d_thr_lo", it),   int'(o_thr_lo),    m_lo);
      check($sformatf("rnd%0d_ro_wait", it),  int'(o_ro_wait),   m_ro);
      check($sformatf("rnd%0d_mod_wait", it), int'(o_mod_wait),  m_mod);
      check($sformatf("rnd%0d_valid", it),    int'(o_cfg_valid), m_valid);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
